ps2_key_event_ctrl: RTL
=======================

Name: ps2_key_event_ctrl

Overview:
- Sits downstream of the PS/2 frame receiver, which delivers one checked byte per valid pulse.
- Sequences the PS/2 set-2 scan-code protocol (E0 extended prefix, F0 break prefix) into whole key events.
- Suppresses typematic repeats in the press count and buffers events in a small FIFO with a valid/ready output toward the consumer (ASCII lookup / display logic).

Parameters:
- FIFO_DEPTH, 8, event FIFO entries; power of two, minimum 2.
- TIMEOUT_CYCLES, 50000, clk cycles allowed between a prefix byte and its following byte before the partial sequence is abandoned.

Ports:
- clk  input  1  system clock.
- resetn  input  1  asynchronous active-low reset.
- byte_valid  input  1  one-cycle pulse: byte_data holds a received byte.
- byte_data  input  8  received scan-code byte.
- byte_err  input  1  qualifies byte_valid; byte had a start/stop/parity error.
- evt_valid  output  1  FIFO head holds an event.
- evt_ready  input  1  consumer accepts the head event.
- evt_code  output  8  final scan code of the head event.
- evt_ext  output  1  head event was E0-prefixed.
- evt_break  output  1  head event is a key release.
- evt_repeat  output  1  head event is a typematic repeat make.
- press_count  output  8  count of non-repeat make events, wraps 255->0.
- ovf  output  1  sticky: an event was dropped because the FIFO was full.
- ovf_clr  input  1  clears ovf.

Behaviour:
- Reset (async assert, sync-safe release): FSM=IDLE, FIFO empty, evt_valid=0, evt_code=0, evt_ext/evt_break/evt_repeat=0, press_count=0, ovf=0, last_make invalid, timeout counter=0.
- FSM states: IDLE, GOT_E0, GOT_F0, GOT_E0F0. Bytes are processed only when byte_valid=1.
- IDLE:
  - E0 -> GOT_E0.
  - F0 -> GOT_F0.
  - Other bytes -> make event {ext=0}, stay in IDLE.
- GOT_E0:
  - F0 -> GOT_E0F0.
  - E0 -> stays in GOT_E0 (restart).
  - Other bytes -> make {ext=1}, then IDLE.
- GOT_F0:
  - F0 ignored.
  - E0 -> GOT_E0 (restart).
  - Other bytes -> break {ext=0}, then IDLE.
- GOT_E0F0:
  - F0 ignored.
  - E0 -> GOT_E0.
  - Other bytes -> break {ext=1}, then IDLE.
- Bytes 0x00 and 0xFF (keyboard error/overrun), and any byte with byte_err=1: discarded, FSM -> IDLE, no event.
- Timeout:
  - Counter clears on every byte_valid and increments each cycle while FSM != IDLE.
  - On reaching TIMEOUT_CYCLES-1 the FSM returns to IDLE and the counter clears.
  - A byte arriving on the same cycle as the timeout takes priority: it is processed and the timeout is ignored.
- Repeat tracking via last_make register {valid, ext, code}:
  - Make equal to last_make while valid -> evt_repeat=1, press_count unchanged.
  - Other make -> evt_repeat=0, press_count+1, last_make updated.
  - Break matching last_make -> last_make invalid.
  - Break not matching -> last_make unchanged.
  - Repeat/count decisions apply even when the event is dropped on overflow.
- FIFO:
  - Event is pushed the cycle after the final byte_valid; evt_* is visible from the FIFO head (show-ahead).
  - Minimum latency from final byte_valid to evt_valid is 2 clk edges.
  - Pop occurs when evt_valid && evt_ready.
  - Full with push and pop on the same cycle: both occur, no overflow.
  - Full with push and no pop: event dropped, ovf set.
  - Empty: evt_valid=0; evt_* fields hold their last value and are don't-care.
  - Pointers wrap modulo FIFO_DEPTH; the count register is log2(FIFO_DEPTH)+1 bits.
- ovf: set has priority over ovf_clr on the same cycle.
- Reset mid-sequence or mid-FIFO: all state is discarded immediately; no events survive.

Decomposition:
- Shared package ps2_pkg:
  - Prefix constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_ERR0=8'h00, PS2_ERR1=8'hFF.
  - FSM state encoding (2 bits).
  - Event record layout {repeat, break, ext, code[7:0]} = 11 bits.
- One sub-module: ps2_evt_fifo, a generic synchronous FIFO (width 11, depth FIFO_DEPTH) with show-ahead output, full/empty flags and simultaneous push/pop when full. The controller instantiates it.

Test Plan:
- Byte 1C, then F0 1C, with evt_ready=1 -> events {1C, ext0, brk0, rep0} and {1C, ext0, brk1}; press_count=1.
- Bytes E0 75, then E0 F0 75 -> events {75, ext1, brk0} and {75, ext1, brk1}; press_count=1.
- Byte 1C sent three times, then F0 1C, then 1C -> rep flags 0,1,1, then break, then rep0; press_count=2.
- evt_ready=0, ten make codes 15..1E with FIFO_DEPTH=8 -> FIFO holds 15..1C, ovf=1, press_count=10. Then ovf_clr -> ovf=0; drain yields 15..1C in order.
- Byte F0, wait TIMEOUT_CYCLES, then 1C -> make 1C (not break). Also: F0, then byte_err pulse, then 1C -> make 1C.
- E0 F0 then resetn low for one cycle, then 1C -> single make {1C, ext0}; press_count=1, ovf=0.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 set-2 key event path: prefix bytes,
// sequencer state encoding and the packed event record.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT  = 8'hE0;
    localparam logic [7:0] PS2_BRK  = 8'hF0;
    localparam logic [7:0] PS2_ERR0 = 8'h00;
    localparam logic [7:0] PS2_ERR1 = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GOT_E0   = 2'd1,
        ST_GOT_F0   = 2'd2,
        ST_GOT_E0F0 = 2'd3
    } ps2_state_t;

    // Event record {repeat, break, ext, code}
    typedef struct packed {
        logic       rep;
        logic       brk;
        logic       ext;
        logic [7:0] code;
    } ps2_evt_t;

    localparam int EVT_W = 11;

    function automatic logic is_err_byte(input logic [7:0] b);
        return (b == PS2_ERR0) || (b == PS2_ERR1);
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Generic synchronous FIFO with show-ahead head output; a push into a full
// FIFO is accepted only when a pop happens on the same cycle.
module ps2_evt_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]    count_reg,  count_next;
    logic             do_push, do_pop;

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == CW'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr_reg];

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (do_push) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage is cleared on reset so the head reads as zero afterwards
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
            localparam logic [AW-1:0] IDX = AW'(gi);
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    mem[gi] <= '0;
                end else if (do_push && (wr_ptr_reg == IDX)) begin
                    mem[gi] <= push_data;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/ps2_key_event_ctrl.sv
// PS/2 set-2 scan-code sequencer: turns checked bytes into make/break key
// events, flags typematic repeats, counts presses and queues events.
module ps2_key_event_ctrl
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    input  logic       byte_err,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_break,
    output logic       evt_repeat,
    output logic [7:0] press_count,
    output logic       ovf,
    input  logic       ovf_clr
);

    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    ps2_state_t     state_reg, state_next;
    logic [TW-1:0]  tmo_cnt_reg, tmo_cnt_next;
    logic           last_valid_reg, last_valid_next;
    logic           last_ext_reg, last_ext_next;
    logic [7:0]     last_code_reg, last_code_next;
    logic [7:0]     press_count_reg, press_count_next;
    logic           pend_valid_reg, pend_valid_next;
    ps2_evt_t       pend_evt_reg, pend_evt_next;
    logic           ovf_reg, ovf_next;

    logic           fire, fire_ext, fire_brk, fire_rep, last_match;
    logic           fifo_full, fifo_empty, fifo_pop, drop;
    logic [EVT_W-1:0] fifo_rd_data;
    ps2_evt_t       head_evt;

    // Sequencer and timeout
    always_comb begin
        state_next   = state_reg;
        tmo_cnt_next = tmo_cnt_reg;
        fire         = 1'b0;
        fire_ext     = 1'b0;
        fire_brk     = 1'b0;

        if (byte_valid) begin
            tmo_cnt_next = '0;
        end else if (state_reg != ST_IDLE) begin
            if (tmo_cnt_reg == TW'(TIMEOUT_CYCLES - 1)) begin
                state_next   = ST_IDLE;
                tmo_cnt_next = '0;
            end else begin
                tmo_cnt_next = tmo_cnt_reg + 1'b1;
            end
        end else begin
            tmo_cnt_next = '0;
        end

        if (byte_valid) begin
            if (byte_err || is_err_byte(byte_data)) begin
                state_next = ST_IDLE;
            end else if (byte_data == PS2_EXT) begin
                state_next = ST_GOT_E0;
            end else if (byte_data == PS2_BRK) begin
                case (state_reg)
                    ST_IDLE:   state_next = ST_GOT_F0;
                    ST_GOT_E0: state_next = ST_GOT_E0F0;
                    default:   state_next = state_reg;
                endcase
            end else begin
                fire       = 1'b1;
                fire_ext   = (state_reg == ST_GOT_E0) || (state_reg == ST_GOT_E0F0);
                fire_brk   = (state_reg == ST_GOT_F0) || (state_reg == ST_GOT_E0F0);
                state_next = ST_IDLE;
            end
        end
    end

    // Repeat tracking runs whether or not the event later fits in the FIFO
    always_comb begin
        last_valid_next  = last_valid_reg;
        last_ext_next    = last_ext_reg;
        last_code_next   = last_code_reg;
        press_count_next = press_count_reg;
        fire_rep         = 1'b0;
        last_match       = last_valid_reg && (last_ext_reg == fire_ext) &&
                           (last_code_reg == byte_data);

        if (fire) begin
            if (fire_brk) begin
                if (last_match) begin
                    last_valid_next = 1'b0;
                end
            end else if (last_match) begin
                fire_rep = 1'b1;
            end else begin
                press_count_next = press_count_reg + 1'b1;
                last_valid_next  = 1'b1;
                last_ext_next    = fire_ext;
                last_code_next   = byte_data;
            end
        end

        pend_valid_next = fire;
        pend_evt_next   = pend_evt_reg;
        if (fire) begin
            pend_evt_next = '{rep: fire_rep, brk: fire_brk, ext: fire_ext, code: byte_data};
        end
    end

    assign fifo_pop = evt_valid && evt_ready;
    assign drop     = pend_valid_reg && fifo_full && !fifo_pop;

    always_comb begin
        ovf_next = ovf_reg;
        if (drop) begin
            ovf_next = 1'b1;
        end else if (ovf_clr) begin
            ovf_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg       <= ST_IDLE;
            tmo_cnt_reg     <= '0;
            last_valid_reg  <= 1'b0;
            last_ext_reg    <= 1'b0;
            last_code_reg   <= '0;
            press_count_reg <= '0;
            pend_valid_reg  <= 1'b0;
            pend_evt_reg    <= '0;
            ovf_reg         <= 1'b0;
        end else begin
            state_reg       <= state_next;
            tmo_cnt_reg     <= tmo_cnt_next;
            last_valid_reg  <= last_valid_next;
            last_ext_reg    <= last_ext_next;
            last_code_reg   <= last_code_next;
            press_count_reg <= press_count_next;
            pend_valid_reg  <= pend_valid_next;
            pend_evt_reg    <= pend_evt_next;
            ovf_reg         <= ovf_next;
        end
    end

    ps2_evt_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (pend_valid_reg),
        .push_data (pend_evt_reg),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign head_evt    = ps2_evt_t'(fifo_rd_data);
    assign evt_valid   = !fifo_empty;
    assign evt_code    = head_evt.code;
    assign evt_ext     = head_evt.ext;
    assign evt_break   = head_evt.brk;
    assign evt_repeat  = head_evt.rep;
    assign press_count = press_count_reg;
    assign ovf         = ovf_reg;

endmodule
